pipeline_memory_stage_mc: RTL and testbench

- Next-generation pipeline memory stage, placed between the execution stage and write-back.
- Replaces the fixed single-cycle data memory with a variable-latency req/ack data bus.
- Generalised in data width and access size; adds misalignment detection, upstream stall generation and a saturating stall-cycle counter.
- Publishes the forwarding tuple (register id, ready, data) to the hazard units of earlier stages.

---
 rtl/pipeline_memory_stage_mc_pkg.sv | 57 +++++
 rtl/pipeline_memory_stage_mc_mem_lane_align.sv | 49 ++++
 rtl/pipeline_memory_stage_mc.sv | 173 +++++++++++++++++
 tb/tb_pipeline_memory_stage_mc.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_memory_stage_mc_pkg.sv
// Shared types and helpers for the memory stage: FSM states, access-size codes
// and the forwarding tuple published to the hazard units.
package pipeline_memory_stage_mc_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam logic [1:0] SIZE_BYTE   = 2'd0;
    localparam logic [1:0] SIZE_HALF   = 2'd1;
    localparam logic [1:0] SIZE_WORD   = 2'd2;
    localparam logic [1:0] SIZE_DOUBLE = 2'd3;

    // The tuple width tracks the default stage datapath; the top's parameters default to these.
    localparam int FWD_ID_WIDTH   = 5;
    localparam int FWD_DATA_WIDTH = 32;

    typedef struct packed {
        logic [FWD_ID_WIDTH-1:0]   id;
        logic                      ready;
        logic [FWD_DATA_WIDTH-1:0] data;
    } fwd_tuple_t;

    function automatic fwd_tuple_t fwd_null();
        fwd_tuple_t t;
        t.id    = {FWD_ID_WIDTH{1'b0}};
        t.ready = 1'b1;
        t.data  = {FWD_DATA_WIDTH{1'b0}};
        return t;
    endfunction

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        logic [3:0] n;
        case (size)
            SIZE_BYTE:   n = 4'd1;
            SIZE_HALF:   n = 4'd2;
            SIZE_WORD:   n = 4'd4;
            SIZE_DOUBLE: n = 4'd8;
            default:     n = 4'd1;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] align_mask(input logic [1:0] size);
        logic [2:0] m;
        case (size)
            SIZE_BYTE:   m = 3'b000;
            SIZE_HALF:   m = 3'b001;
            SIZE_WORD:   m = 3'b011;
            SIZE_DOUBLE: m = 3'b111;
            default:     m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pipeline_memory_stage_mc_mem_lane_align.sv
// Byte-lane steering between the right-aligned pipeline operands and the
// naturally aligned data bus: store strobes/replication and load extraction.
module mem_lane_align
    import pipeline_memory_stage_mc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LANE_W     = $clog2(DATA_WIDTH / 8)
) (
    input  logic [LANE_W-1:0]       i_offset,
    input  logic [1:0]              i_size,
    input  logic                    i_signed,
    input  logic [DATA_WIDTH-1:0]   i_store_data,
    input  logic [DATA_WIDTH-1:0]   i_rdata,
    output logic [DATA_WIDTH/8-1:0] o_wstrb,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [DATA_WIDTH-1:0]   o_load_data
);

    localparam int BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] w_shifted;
    logic                  w_sign;

    // Lane steering; an illegal (oversized) access only yields don't-care lanes since it never reaches the bus.
    always_comb begin
        int nb;
        int off;
        nb          = int'(size_bytes(i_size));
        off         = int'(i_offset);
        o_wstrb     = {BYTES{1'b0}};
        o_wdata     = {DATA_WIDTH{1'b0}};
        o_load_data = {DATA_WIDTH{1'b0}};
        w_shifted   = i_rdata >> (off * 8);
        w_sign      = 1'b0;
        for (int b = 0; b < BYTES; b++) begin
            o_wstrb[b]       = (b >= off) && (b < off + nb);
            o_wdata[8*b +: 8] = i_store_data[8*(b & (nb - 1)) +: 8];
            if (b == nb - 1) begin
                w_sign = w_shifted[8*b + 7];
            end else begin
                w_sign = w_sign;
            end
        end
        for (int b = 0; b < BYTES; b++) begin
            o_load_data[8*b +: 8] = (b < nb) ? w_shifted[8*b +: 8] : {8{i_signed & w_sign}};
        end
    end

endmodule

// File: rtl/pipeline_memory_stage_mc.sv
// Memory stage between execute and write-back: variable-latency req/ack data bus,
// misalignment trapping, upstream stall, forwarding tuple and stall-cycle counter.
module pipeline_memory_stage_mc
    import pipeline_memory_stage_mc_pkg::*;
#(
    parameter int DATA_WIDTH   = FWD_DATA_WIDTH,
    parameter int ADDR_WIDTH   = 32,
    parameter int REG_ID_WIDTH = FWD_ID_WIDTH,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [ADDR_WIDTH-1:0]   in_pc,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic                    in_load,
    input  logic                    in_store,
    input  logic [1:0]              in_size,
    input  logic                    in_signed,
    input  logic [DATA_WIDTH-1:0]   in_store_data,
    input  logic                    in_rw_en,
    input  logic [REG_ID_WIDTH-1:0] in_rw_id,
    input  logic                    in_rw_ready,
    input  logic [DATA_WIDTH-1:0]   in_rw_data,
    output logic                    stall_upstream,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    out_valid,
    output logic [ADDR_WIDTH-1:0]   out_pc,
    output logic                    out_misaligned,
    output logic [REG_ID_WIDTH-1:0] out_rw_id,
    output logic                    out_rw_ready,
    output logic [DATA_WIDTH-1:0]   out_rw_data,
    output logic [REG_ID_WIDTH-1:0] fwd_id,
    output logic                    fwd_ready,
    output logic [DATA_WIDTH-1:0]   fwd_data,
    output logic [CNT_WIDTH-1:0]    stall_cycles
);

    localparam int                    BYTES     = DATA_WIDTH / 8;
    localparam int                    LANE_W    = $clog2(BYTES);
    localparam logic [1:0]            MAX_SIZE  = (LANE_W >= 3) ? SIZE_DOUBLE : 2'(LANE_W);
    localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(BYTES - 1);

    state_e                r_state;
    logic                  r_out_valid;
    logic                  r_out_mis;
    logic [ADDR_WIDTH-1:0] r_out_pc;
    fwd_tuple_t            r_out;
    fwd_tuple_t            r_fwd;
    logic [CNT_WIDTH-1:0]  r_cnt;

    logic                  w_mem_op;
    logic                  w_size_legal;
    logic                  w_aligned;
    logic                  w_misaligned;
    logic                  w_req;
    logic                  w_stall;
    logic                  w_capture;
    logic                  w_cap_mis;
    fwd_tuple_t            w_cap;
    logic [BYTES-1:0]      w_strb;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_load_data;

    // An oversized access is folded into the misaligned trap so it never reaches the bus.
    assign w_mem_op     = in_valid & (in_load | in_store);
    assign w_size_legal = (in_size <= MAX_SIZE);
    assign w_aligned    = ((in_addr[2:0] & align_mask(in_size)) == 3'd0);
    assign w_misaligned = w_mem_op & ~(w_size_legal & w_aligned);
    assign w_req        = ((r_state == IDLE) & w_mem_op & ~w_misaligned) | (r_state == WAIT);
    assign w_stall      = w_req & ~mem_ack;
    assign w_capture    = ((r_state == IDLE) & ~w_stall) | ((r_state == WAIT) & mem_ack);

    mem_lane_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANE_W     (LANE_W)
    ) u_lane_align (
        .i_offset     (in_addr[LANE_W-1:0]),
        .i_size       (in_size),
        .i_signed     (in_signed),
        .i_store_data (in_store_data),
        .i_rdata      (mem_rdata),
        .o_wstrb      (w_strb),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data)
    );

    // Write-back tuple for the instruction currently presented, in capture priority order.
    always_comb begin
        w_cap     = fwd_null();
        w_cap_mis = 1'b0;
        if (w_misaligned) begin
            w_cap_mis = 1'b1;
        end else if (!in_rw_en) begin
            w_cap = fwd_null();
        end else if (in_rw_ready) begin
            w_cap.id    = in_rw_id;
            w_cap.ready = 1'b1;
            w_cap.data  = in_rw_data;
        end else if (in_load) begin
            w_cap.id    = in_rw_id;
            w_cap.ready = 1'b1;
            w_cap.data  = w_load_data;
        end else begin
            w_cap.id    = in_rw_id;
            w_cap.ready = 1'b0;
            w_cap.data  = {DATA_WIDTH{1'b0}};
        end
    end

    // FSM and output/forwarding capture; a bubble or WAIT leaves the payload fields untouched.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_out_mis   <= 1'b0;
            r_out_pc    <= {ADDR_WIDTH{1'b0}};
            r_out       <= fwd_null();
            r_fwd       <= fwd_null();
        end else begin
            case (r_state)
                IDLE:    r_state <= w_stall ? WAIT : IDLE;
                WAIT:    r_state <= mem_ack ? IDLE : WAIT;
                default: r_state <= IDLE;
            endcase
            if (w_capture && in_valid) begin
                r_out_valid <= 1'b1;
                r_out_mis   <= w_cap_mis;
                r_out_pc    <= in_pc;
                r_out       <= w_cap;
                r_fwd       <= w_cap;
            end else begin
                r_out_valid <= 1'b0;
                r_fwd       <= fwd_null();
            end
        end
    end

    // Saturating count of cycles in which upstream was held.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= {CNT_WIDTH{1'b0}};
        end else if (w_stall && (r_cnt != {CNT_WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign stall_upstream = w_stall;
    assign mem_req        = w_req;
    assign mem_we         = in_store;
    assign mem_addr       = in_addr & ~LANE_MASK;
    assign mem_wstrb      = w_strb;
    assign mem_wdata      = w_wdata;
    assign out_valid      = r_out_valid;
    assign out_pc         = r_out_pc;
    assign out_misaligned = r_out_mis;
    assign out_rw_id      = r_out.id;
    assign out_rw_ready   = r_out.ready;
    assign out_rw_data    = r_out.data;
    assign fwd_id         = r_fwd.id;
    assign fwd_ready      = r_fwd.ready;
    assign fwd_data       = r_fwd.data;
    assign stall_cycles   = r_cnt;

endmodule

// File: tb/tb_pipeline_memory_stage_mc.sv
// Self-checking bench: directed vector table, randomized vectors against a
// behavioural model, and a reset-during-WAIT sequence.
module tb_pipeline_memory_stage_mc;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RW = 5;
    localparam int CW = 4;

    logic          clock, reset;
    logic          in_valid, in_load, in_store, in_signed, in_rw_en, in_rw_ready;
    logic [AW-1:0] in_pc, in_addr;
    logic [1:0]    in_size;
    logic [DW-1:0] in_store_data, in_rw_data, mem_rdata;
    logic [RW-1:0] in_rw_id;
    logic          stall_upstream, mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr, out_pc;
    logic [3:0]    mem_wstrb;
    logic [DW-1:0] mem_wdata, out_rw_data, fwd_data;
    logic          out_valid, out_misaligned, out_rw_ready, fwd_ready;
    logic [RW-1:0] out_rw_id, fwd_id;
    logic [CW-1:0] stall_cycles;

    pipeline_memory_stage_mc #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_ID_WIDTH(RW), .CNT_WIDTH(CW)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_pc(in_pc), .in_addr(in_addr), .in_load(in_load),
        .in_store(in_store), .in_size(in_size), .in_signed(in_signed),
        .in_store_data(in_store_data), .in_rw_en(in_rw_en), .in_rw_id(in_rw_id),
        .in_rw_ready(in_rw_ready), .in_rw_data(in_rw_data),
        .stall_upstream(stall_upstream), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_pc(out_pc), .out_misaligned(out_misaligned),
        .out_rw_id(out_rw_id), .out_rw_ready(out_rw_ready), .out_rw_data(out_rw_data),
        .fwd_id(fwd_id), .fwd_ready(fwd_ready), .fwd_data(fwd_data),
        .stall_cycles(stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Upstream must keep every in_* stable while it is being stalled.
    assert property (@(posedge clock) disable iff (reset)
        stall_upstream |=> $stable({in_valid, in_pc, in_addr, in_load, in_store, in_size,
                                    in_signed, in_store_data, in_rw_en, in_rw_id,
                                    in_rw_ready, in_rw_data}))
        else $error("FAIL protocol: in_* changed while stall_upstream was high");

    typedef struct {
        logic        valid, load, store;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr, sdata;
        logic        rw_en;
        logic [4:0]  rw_id;
        logic        rw_ready;
        logic [31:0] rw_data, rdata;
        int          lat;
        logic        exp_mis;
        logic [4:0]  exp_id;
        logic        exp_ready;
        logic [31:0] exp_data;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    logic        m_mis, m_ready;
    logic [4:0]  m_id;
    logic [31:0] m_data, m_pc;
    int          m_cnt;
    int          pc_seq = 0;
    vec_t        tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit ref_req(input vec_t v);
        int n = 1 << v.size;
        return v.valid && (v.load || v.store) && (n <= 4) && (v.addr % n == 0);
    endfunction

    // Reference: expected write-back/bus values straight from the access rules.
    function automatic vec_t ref_fill(input vec_t v);
        vec_t r = v;
        int n = 1 << v.size;
        bit mem_op = v.valid && (v.load || v.store);
        bit ok = (n <= 4) && (v.addr % n == 0);
        int off = v.addr % 4;
        longint unsigned mask = (64'd1 << (8 * n)) - 64'd1;
        longint unsigned rep, val;
        r.exp_strb = 4'(((1 << n) - 1) << off);
        rep = {32'd0, v.sdata} & mask;
        if (n == 1)      r.exp_wdata = 32'(rep * 64'h0101_0101);
        else if (n == 2) r.exp_wdata = 32'(rep * 64'h0001_0001);
        else             r.exp_wdata = 32'(rep);
        val = ({32'd0, v.rdata} >> (8 * off)) & mask;
        if (v.sgn && val >= (mask + 64'd1) / 64'd2) val = val - (mask + 64'd1);
        r.exp_mis = 1'b0; r.exp_id = 5'd0; r.exp_ready = 1'b1; r.exp_data = 32'd0;
        if (!v.valid) begin
            r.exp_mis = m_mis; r.exp_id = m_id; r.exp_ready = m_ready; r.exp_data = m_data;
        end else if (mem_op && !ok) begin
            r.exp_mis = 1'b1;
        end else if (!v.rw_en) begin
            r.exp_id = 5'd0;
        end else if (v.rw_ready) begin
            r.exp_id = v.rw_id; r.exp_data = v.rw_data;
        end else if (v.load) begin
            r.exp_id = v.rw_id; r.exp_data = val[31:0];
        end else begin
            r.exp_id = v.rw_id; r.exp_ready = 1'b0;
        end
        return r;
    endfunction

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; mem_ack = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        m_mis = 1'b0; m_id = 5'd0; m_ready = 1'b1; m_data = 32'd0; m_pc = 32'd0; m_cnt = 0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        bit req = ref_req(v);
        int lat = req ? v.lat : 0;
        logic [31:0] pc = 32'h1000 + 32'(4 * pc_seq);
        pc_seq++;
        in_valid = v.valid; in_pc = pc; in_addr = v.addr; in_load = v.load; in_store = v.store;
        in_size = v.size; in_signed = v.sgn; in_store_data = v.sdata; in_rw_en = v.rw_en;
        in_rw_id = v.rw_id; in_rw_ready = v.rw_ready; in_rw_data = v.rw_data;
        for (int w = 0; w <= lat; w++) begin
            mem_ack   = req && (w == lat);
            mem_rdata = (w == lat) ? v.rdata : 32'hDEAD_BEEF;
            #1;
            chk({tag, " mem_req"}, mem_req, req);
            chk({tag, " stall_upstream"}, stall_upstream, req && (w < lat));
            if (req && w == 0) begin
                chk({tag, " mem_we"}, mem_we, v.store);
                chk({tag, " mem_addr"}, mem_addr, v.addr & 32'hFFFF_FFFC);
                if (v.store) begin
                    chk({tag, " mem_wstrb"}, mem_wstrb, v.exp_strb);
                    chk({tag, " mem_wdata"}, mem_wdata, v.exp_wdata);
                end
            end
            if (req && w < lat && m_cnt < 15) m_cnt++;
            @(posedge clock);
            #1;
            if (w < lat) chk({tag, " out_valid_in_wait"}, out_valid, 1'b0);
        end
        mem_ack = 1'b0;
        chk({tag, " out_valid"}, out_valid, v.valid);
        chk({tag, " out_pc"}, out_pc, v.valid ? pc : m_pc);
        chk({tag, " out_misaligned"}, out_misaligned, v.exp_mis);
        chk({tag, " out_rw_id"}, out_rw_id, v.exp_id);
        chk({tag, " out_rw_ready"}, out_rw_ready, v.exp_ready);
        chk({tag, " out_rw_data"}, out_rw_data, v.exp_data);
        chk({tag, " fwd_id"}, fwd_id, v.valid ? v.exp_id : 5'd0);
        chk({tag, " fwd_ready"}, fwd_ready, v.valid ? v.exp_ready : 1'b1);
        chk({tag, " fwd_data"}, fwd_data, v.valid ? v.exp_data : 32'd0);
        chk({tag, " stall_cycles"}, stall_cycles, 64'(m_cnt));
        m_mis = v.exp_mis; m_id = v.exp_id; m_ready = v.exp_ready; m_data = v.exp_data;
        if (v.valid) m_pc = pc;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        in_pc = 32'd0; in_addr = 32'd0; in_size = 2'd0; in_signed = 1'b0; in_store_data = 32'd0;
        in_rw_en = 1'b0; in_rw_id = 5'd0; in_rw_ready = 1'b0; in_rw_data = 32'd0;
        mem_rdata = 32'd0;
        do_reset();
        #1;
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset out_misaligned", out_misaligned, 1'b0);
        chk("reset out_rw_id", out_rw_id, 5'd0);
        chk("reset out_rw_ready", out_rw_ready, 1'b1);
        chk("reset out_rw_data", out_rw_data, 32'd0);
        chk("reset fwd", {fwd_id, fwd_ready, fwd_data}, {5'd0, 1'b1, 32'd0});
        chk("reset stall_cycles", stall_cycles, 4'd0);
        chk("reset mem_req", mem_req, 1'b0);
        @(posedge clock); #1;

        // valid load store size sgn addr sdata rw_en id rdy rw_data rdata lat | mis id rdy data strb wdata
        tbl[0]  = '{1'b1,1'b1,1'b0,2'd2,1'b1,32'h104,32'h0,1'b1,5'd3,1'b0,32'h0,32'h8000_00F0,0,
                    1'b0,5'd3,1'b1,32'h8000_00F0,4'h0,32'h0};
        tbl[1]  = '{1'b1,1'b1,1'b0,2'd0,1'b1,32'h103,32'h0,1'b1,5'd4,1'b0,32'h0,32'h8000_0000,3,
                    1'b0,5'd4,1'b1,32'hFFFF_FF80,4'h0,32'h0};
        tbl[2]  = '{1'b1,1'b0,1'b1,2'd1,1'b0,32'h102,32'hABCD_1234,1'b0,5'd0,1'b0,32'h0,32'h0,1,
                    1'b0,5'd0,1'b1,32'h0,4'b1100,32'h1234_1234};
        tbl[3]  = '{1'b1,1'b1,1'b0,2'd2,1'b0,32'h101,32'h0,1'b1,5'd6,1'b0,32'h0,32'h0,2,
                    1'b1,5'd0,1'b1,32'h0,4'h0,32'h0};
        tbl[4]  = '{1'b1,1'b0,1'b0,2'd0,1'b0,32'h0,32'h0,1'b1,5'd7,1'b1,32'h5,32'h0,0,
                    1'b0,5'd7,1'b1,32'h5,4'h0,32'h0};
        tbl[5]  = '{1'b0,1'b0,1'b0,2'd0,1'b0,32'h0,32'h0,1'b0,5'd0,1'b0,32'h0,32'h0,0,
                    1'b0,5'd7,1'b1,32'h5,4'h0,32'h0};
        tbl[6]  = '{1'b1,1'b1,1'b0,2'd3,1'b0,32'h100,32'h0,1'b1,5'd8,1'b0,32'h0,32'h0,1,
                    1'b1,5'd0,1'b1,32'h0,4'h0,32'h0};
        tbl[7]  = '{1'b1,1'b1,1'b0,2'd1,1'b0,32'h106,32'h0,1'b1,5'd9,1'b0,32'h0,32'hFFFE_0000,2,
                    1'b0,5'd9,1'b1,32'h0000_FFFE,4'h0,32'h0};
        tbl[8]  = '{1'b1,1'b0,1'b1,2'd0,1'b0,32'h101,32'h1234_565A,1'b0,5'd0,1'b0,32'h0,32'h0,0,
                    1'b0,5'd0,1'b1,32'h0,4'b0010,32'h5A5A_5A5A};
        tbl[9]  = '{1'b1,1'b0,1'b0,2'd0,1'b0,32'h0,32'h0,1'b1,5'd12,1'b0,32'h77,32'h0,0,
                    1'b0,5'd12,1'b0,32'h0,4'h0,32'h0};
        tbl[10] = '{1'b1,1'b0,1'b0,2'd0,1'b0,32'h0,32'h0,1'b0,5'd5,1'b1,32'h9,32'h0,0,
                    1'b0,5'd0,1'b1,32'h0,4'h0,32'h0};
        tbl[11] = '{1'b1,1'b1,1'b0,2'd1,1'b1,32'h102,32'h0,1'b1,5'd31,1'b0,32'h0,32'h8001_1111,1,
                    1'b0,5'd31,1'b1,32'hFFFF_8001,4'h0,32'h0};
        for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        do_reset();
        for (int i = 0; i < 300; i++) begin
            int kind = $urandom_range(0, 2);
            v.valid = ($urandom_range(0, 9) != 0);
            v.load = (kind == 1); v.store = (kind == 2);
            v.size = 2'($urandom_range(0, 3)); v.sgn = 1'($urandom);
            v.addr = 32'h2000 + 32'($urandom_range(0, 63)); v.sdata = $urandom;
            v.rw_en = ($urandom_range(0, 3) != 0); v.rw_id = 5'($urandom);
            v.rw_ready = ($urandom_range(0, 3) == 0); v.rw_data = $urandom;
            v.rdata = $urandom; v.lat = $urandom_range(0, 3);
            v = ref_fill(v);
            run_vec(v, $sformatf("rnd%0d", i));
        end

        // Reset during the second WAIT cycle abandons the access.
        do_reset();
        in_valid = 1'b1; in_pc = 32'h4000; in_addr = 32'h300; in_load = 1'b1; in_store = 1'b0;
        in_size = 2'd2; in_signed = 1'b0; in_rw_en = 1'b1; in_rw_id = 5'd2; in_rw_ready = 1'b0;
        mem_ack = 1'b0;
        #1;
        chk("rstwait req_c0", mem_req, 1'b1);
        @(posedge clock); #1;
        chk("rstwait req_c1", mem_req, 1'b1);
        chk("rstwait out_valid_c1", out_valid, 1'b0);
        chk("rstwait stall_c1", stall_cycles, 4'd1);
        @(posedge clock); #1;
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        m_mis = 1'b0; m_id = 5'd0; m_ready = 1'b1; m_data = 32'd0; m_pc = 32'd0; m_cnt = 0;
        chk("rstwait mem_req_after", mem_req, 1'b0);
        chk("rstwait out_valid_after", out_valid, 1'b0);
        chk("rstwait stall_after", stall_cycles, 4'd0);
        v = '{1'b1,1'b1,1'b0,2'd2,1'b0,32'h308,32'h0,1'b1,5'd10,1'b0,32'h0,32'hCAFE_F00D,2,
              1'b0,5'd0,1'b0,32'h0,4'h0,32'h0};
        v = ref_fill(v);
        run_vec(v, "post_reset_load");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
